// File: rtl/vend_pkg.sv
// Shared vending definitions: default prices, FSM/item encodings and coin legality.
package vend_pkg;

    localparam int unsigned TeaPriceDef    = 5;
    localparam int unsigned CoffeePriceDef = 10;
    localparam int unsigned LemonPriceDef  = 20;

    typedef enum logic [2:0] {
        StIdle,
        StCollect,
        StDispense,
        StChange,
        StRefund
    } vend_state_t;

    typedef enum logic [1:0] {
        ItemNone,
        ItemTea,
        ItemCoffee,
        ItemLemon
    } item_t;

    function automatic logic is_legal_coin(logic [7:0] value);
        return (value == 8'd5) || (value == 8'd10) || (value == 8'd20);
    endfunction

endpackage

// File: rtl/vend_timeout_counter.sv
// Inactivity counter for the credit-collection phase; expire holds once the last count is reached.
module vend_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int unsigned Width = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [Width-1:0] LastCount = Width'(TIMEOUT_CYCLES - 1);

    logic [Width-1:0] count_q;

    assign expire = (count_q == LastCount);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_q <= '0;
        end else if (enable && !expire) begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/coin_credit_accumulator.sv
// Coin credit accumulator: collects coins, arbitrates selections, and emits vend/change/refund
// pulses, all from registered outputs.
module coin_credit_accumulator
    import vend_pkg::*;
#(
    parameter int unsigned TEA_PRICE       = TeaPriceDef,
    parameter int unsigned COFFEE_PRICE    = CoffeePriceDef,
    parameter int unsigned LEMON_TEA_PRICE = LemonPriceDef,
    parameter int unsigned MAX_CREDIT      = 40,
    parameter int unsigned TIMEOUT_CYCLES  = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       coin_valid,
    input  logic [7:0] coin_value,
    input  logic       T3,
    input  logic       R2,
    input  logic       U1,
    input  logic       cancel,
    output logic [7:0] coin,
    output logic       T3_out,
    output logic       R2_out,
    output logic       U1_out,
    output logic [7:0] credit,
    output logic       coin_reject,
    output logic       change_valid,
    output logic [7:0] change_amount,
    output logic       busy
);

    vend_state_t state_q, state_d;
    item_t       item_q, item_d, sel_item;
    logic [7:0]  credit_q, credit_d;
    logic [7:0]  coin_d, change_amount_d, sel_price, remainder;
    logic        t3_d, r2_d, u1_d, reject_d, change_valid_d, busy_d;
    logic        tmo_clear, tmo_enable, tmo_expire;
    logic [8:0]  sum;
    logic        coin_ok;

    function automatic logic [7:0] price_of(item_t it);
        case (it)
            ItemTea:    return 8'(TEA_PRICE);
            ItemCoffee: return 8'(COFFEE_PRICE);
            ItemLemon:  return 8'(LEMON_TEA_PRICE);
            default:    return 8'd0;
        endcase
    endfunction

    // 9-bit sum so the ceiling check can never be fooled by wrap-around.
    assign sum     = {1'b0, credit_q} + {1'b0, coin_value};
    assign coin_ok = coin_valid && is_legal_coin(coin_value) && (sum <= 9'(MAX_CREDIT));
    assign credit  = credit_q;

    always_comb begin
        sel_item = ItemNone;
        if (T3) begin
            sel_item = ItemTea;
        end else if (R2) begin
            sel_item = ItemCoffee;
        end else if (U1) begin
            sel_item = ItemLemon;
        end
        sel_price = price_of(sel_item);
        remainder = credit_q - price_of(item_q);
    end

    always_comb begin
        state_d         = state_q;
        credit_d        = credit_q;
        item_d          = item_q;
        coin_d          = 8'd0;
        t3_d            = 1'b0;
        r2_d            = 1'b0;
        u1_d            = 1'b0;
        reject_d        = 1'b0;
        change_valid_d  = 1'b0;
        change_amount_d = 8'd0;
        tmo_clear       = 1'b1;
        tmo_enable      = 1'b0;

        case (state_q)
            StIdle: begin
                item_d   = ItemNone;
                credit_d = 8'd0;
                if (coin_ok) begin
                    credit_d = sum[7:0];
                    state_d  = StCollect;
                end else begin
                    reject_d = coin_valid;
                end
            end
            StCollect: begin
                tmo_clear = 1'b0;
                if (cancel) begin
                    reject_d        = coin_valid;
                    change_valid_d  = 1'b1;
                    change_amount_d = credit_q;
                    state_d         = StRefund;
                end else if (coin_ok) begin
                    credit_d  = sum[7:0];
                    tmo_clear = 1'b1;
                end else begin
                    reject_d = coin_valid;
                    // Highest-priority pressed button wins; it only vends if affordable.
                    if (sel_item != ItemNone && credit_q >= sel_price) begin
                        item_d  = sel_item;
                        coin_d  = sel_price;
                        t3_d    = (sel_item == ItemTea);
                        r2_d    = (sel_item == ItemCoffee);
                        u1_d    = (sel_item == ItemLemon);
                        state_d = StDispense;
                    end else if (tmo_expire) begin
                        change_valid_d  = 1'b1;
                        change_amount_d = credit_q;
                        state_d         = StRefund;
                    end else begin
                        tmo_enable = 1'b1;
                    end
                end
            end
            StDispense: begin
                reject_d        = coin_valid;
                credit_d        = remainder;
                change_valid_d  = (remainder != 8'd0);
                change_amount_d = remainder;
                state_d         = StChange;
            end
            StChange, StRefund: begin
                reject_d = coin_valid;
                credit_d = 8'd0;
                item_d   = ItemNone;
                state_d  = StIdle;
            end
            default: begin
                credit_d = 8'd0;
                item_d   = ItemNone;
                state_d  = StIdle;
            end
        endcase

        busy_d = (state_d == StDispense) || (state_d == StChange) || (state_d == StRefund);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            item_q        <= ItemNone;
            credit_q      <= 8'd0;
            coin          <= 8'd0;
            T3_out        <= 1'b0;
            R2_out        <= 1'b0;
            U1_out        <= 1'b0;
            coin_reject   <= 1'b0;
            change_valid  <= 1'b0;
            change_amount <= 8'd0;
            busy          <= 1'b0;
        end else begin
            state_q       <= state_d;
            item_q        <= item_d;
            credit_q      <= credit_d;
            coin          <= coin_d;
            T3_out        <= t3_d;
            R2_out        <= r2_d;
            U1_out        <= u1_d;
            coin_reject   <= reject_d;
            change_valid  <= change_valid_d;
            change_amount <= change_amount_d;
            busy          <= busy_d;
        end
    end

    vend_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk   (clk),
        .reset (reset),
        .clear (tmo_clear),
        .enable(tmo_enable),
        .expire(tmo_expire)
    );

endmodule

// File: tb/tb_coin_credit_accumulator.sv
// Self-checking bench: directed scenarios plus randomized traffic against a transaction-level model.
module tb_coin_credit_accumulator;

    localparam int unsigned Tmo      = 16;
    localparam int unsigned MaxCred  = 40;
    localparam int unsigned PTea     = 5;
    localparam int unsigned PCoffee  = 10;
    localparam int unsigned PLemon   = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       coin_valid = 1'b0;
    logic [7:0] coin_value = 8'd0;
    logic       T3 = 1'b0, R2 = 1'b0, U1 = 1'b0, cancel = 1'b0;
    logic [7:0] coin, credit, change_amount;
    logic       T3_out, R2_out, U1_out, coin_reject, change_valid, busy;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic [7:0] coin;
        logic       t3, r2, u1;
        logic [7:0] credit;
        logic       rej, cv;
        logic [7:0] camt;
        logic       busy;
    } exp_t;

    exp_t exp_cur;
    exp_t script[$];
    int unsigned m_idle;

    always #5 clk = ~clk;

    coin_credit_accumulator #(
        .TEA_PRICE      (PTea),
        .COFFEE_PRICE   (PCoffee),
        .LEMON_TEA_PRICE(PLemon),
        .MAX_CREDIT     (MaxCred),
        .TIMEOUT_CYCLES (Tmo)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .coin_valid   (coin_valid),
        .coin_value   (coin_value),
        .T3           (T3),
        .R2           (R2),
        .U1           (U1),
        .cancel       (cancel),
        .coin         (coin),
        .T3_out       (T3_out),
        .R2_out       (R2_out),
        .U1_out       (U1_out),
        .credit       (credit),
        .coin_reject  (coin_reject),
        .change_valid (change_valid),
        .change_amount(change_amount),
        .busy         (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        coin_valid = 1'b0; coin_value = 8'd0;
        T3 = 1'b0; R2 = 1'b0; U1 = 1'b0; cancel = 1'b0;
    endtask

    task automatic settle();
        idle_inputs();
        repeat (4) step();
    endtask

    // Reference: credit > 0 means a session is open; a vend/refund is a short script of
    // expected outputs during which the machine is busy and refuses coins.
    task automatic model_step();
        exp_t e, after;
        int unsigned c, p, sel;
        bit acc;
        e = '0;
        if (reset) begin
            script.delete();
            m_idle  = 0;
            exp_cur = '0;
            return;
        end
        c = exp_cur.credit;
        if (exp_cur.busy) begin
            if (script.size() > 0) e = script.pop_front();
            e.rej = coin_valid;
        end else begin
            e.credit = c[7:0];
            acc = 1'b0;
            if (c != 0 && cancel) begin
                e.rej = coin_valid; e.cv = 1'b1; e.camt = c[7:0]; e.busy = 1'b1; m_idle = 0;
            end else begin
                if (coin_valid) begin
                    if ((coin_value == 5 || coin_value == 10 || coin_value == 20) &&
                        c + coin_value <= MaxCred) begin
                        acc = 1'b1; c = c + coin_value; e.credit = c[7:0]; m_idle = 0;
                    end else begin
                        e.rej = 1'b1;
                    end
                end
                if (c != 0 && !acc) begin
                    sel = T3 ? 1 : R2 ? 2 : U1 ? 3 : 0;
                    p = (sel == 1) ? PTea : (sel == 2) ? PCoffee : (sel == 3) ? PLemon : 0;
                    if (sel != 0 && c >= p) begin
                        e.coin = p[7:0];
                        e.t3 = (sel == 1); e.r2 = (sel == 2); e.u1 = (sel == 3);
                        e.busy = 1'b1;
                        after = '0;
                        after.credit = 8'(c - p);
                        after.cv     = (c != p);
                        after.camt   = 8'(c - p);
                        after.busy   = 1'b1;
                        script.push_back(after);
                        m_idle = 0;
                    end else if (m_idle == Tmo - 1) begin
                        e.cv = 1'b1; e.camt = c[7:0]; e.busy = 1'b1; m_idle = 0;
                    end else begin
                        m_idle++;
                    end
                end
            end
        end
        exp_cur = e;
    endtask

    task automatic test_reset();
        reset = 1'b1; coin_valid = 1'b1; coin_value = 8'd10; T3 = 1'b1;
        step();
        n_checks++; if (credit !== 8'd0) $display("FAIL reset_credit: got %0d want 0", credit); else n_pass++;
        n_checks++; if ({coin, T3_out, R2_out, U1_out, coin_reject, change_valid, change_amount, busy} !== '0)
            $display("FAIL reset_outputs: got %h want 0",
                     {coin, T3_out, R2_out, U1_out, coin_reject, change_valid, change_amount, busy});
        else n_pass++;
        reset = 1'b0;
        settle();
    endtask

    task automatic test_tea_exact();
        idle_inputs(); coin_valid = 1'b1; coin_value = 8'd5; step();
        n_checks++; if (credit !== 8'd5) $display("FAIL tea_credit1: got %0d want 5", credit); else n_pass++;
        step();
        n_checks++; if (credit !== 8'd10) $display("FAIL tea_credit2: got %0d want 10", credit); else n_pass++;
        coin_valid = 1'b0; T3 = 1'b1; step();
        n_checks++; if (coin !== 8'd5 || T3_out !== 1'b1 || R2_out !== 1'b0 || U1_out !== 1'b0 || busy !== 1'b1)
            $display("FAIL tea_dispense: got coin=%0d t3=%b r2=%b u1=%b busy=%b want 5 1 0 0 1",
                     coin, T3_out, R2_out, U1_out, busy);
        else n_pass++;
        step();
        n_checks++; if (change_valid !== 1'b1 || change_amount !== 8'd5 || T3_out !== 1'b0 || coin !== 8'd0)
            $display("FAIL tea_change: got cv=%b amt=%0d t3=%b coin=%0d want 1 5 0 0",
                     change_valid, change_amount, T3_out, coin);
        else n_pass++;
        step();
        n_checks++; if (credit !== 8'd0 || change_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL tea_after: got credit=%0d cv=%b busy=%b want 0 0 0", credit, change_valid, busy);
        else n_pass++;
        step();
        n_checks++; if (T3_out !== 1'b0 || coin !== 8'd0)
            $display("FAIL tea_no_retrigger: got t3=%b coin=%0d want 0 0", T3_out, coin);
        else n_pass++;
        settle();
    endtask

    task automatic test_ceiling_coffee();
        idle_inputs(); coin_valid = 1'b1; coin_value = 8'd20; step(); step();
        n_checks++; if (credit !== 8'd40) $display("FAIL ceil_credit: got %0d want 40", credit); else n_pass++;
        coin_value = 8'd5; step();
        n_checks++; if (coin_reject !== 1'b1 || credit !== 8'd40)
            $display("FAIL ceil_reject: got rej=%b credit=%0d want 1 40", coin_reject, credit);
        else n_pass++;
        coin_valid = 1'b0; R2 = 1'b1; step();
        n_checks++; if (coin !== 8'd10 || R2_out !== 1'b1 || T3_out !== 1'b0 || coin_reject !== 1'b0)
            $display("FAIL coffee_dispense: got coin=%0d r2=%b t3=%b rej=%b want 10 1 0 0",
                     coin, R2_out, T3_out, coin_reject);
        else n_pass++;
        R2 = 1'b0; step();
        n_checks++; if (change_valid !== 1'b1 || change_amount !== 8'd30)
            $display("FAIL coffee_change: got cv=%b amt=%0d want 1 30", change_valid, change_amount);
        else n_pass++;
        settle();
    endtask

    task automatic test_illegal_coin();
        idle_inputs(); coin_valid = 1'b1; coin_value = 8'd7; step();
        n_checks++; if (coin_reject !== 1'b1 || credit !== 8'd0)
            $display("FAIL illegal_reject: got rej=%b credit=%0d want 1 0", coin_reject, credit);
        else n_pass++;
        coin_valid = 1'b0; T3 = 1'b1; step();
        n_checks++; if (coin_reject !== 1'b0 || busy !== 1'b0 || T3_out !== 1'b0 || credit !== 8'd0)
            $display("FAIL illegal_idle: got rej=%b busy=%b t3=%b credit=%0d want 0 0 0 0",
                     coin_reject, busy, T3_out, credit);
        else n_pass++;
        settle();
    endtask

    task automatic test_priority();
        idle_inputs(); coin_valid = 1'b1; coin_value = 8'd10; step();
        coin_valid = 1'b0; T3 = 1'b1; U1 = 1'b1; step();
        n_checks++; if (coin !== 8'd5 || T3_out !== 1'b1 || U1_out !== 1'b0 || R2_out !== 1'b0)
            $display("FAIL prio_dispense: got coin=%0d t3=%b r2=%b u1=%b want 5 1 0 0",
                     coin, T3_out, R2_out, U1_out);
        else n_pass++;
        idle_inputs(); step();
        n_checks++; if (change_valid !== 1'b1 || change_amount !== 8'd5)
            $display("FAIL prio_change: got cv=%b amt=%0d want 1 5", change_valid, change_amount);
        else n_pass++;
        settle();
    endtask

    task automatic test_cancel_timeout();
        int waited;
        idle_inputs(); coin_valid = 1'b1; coin_value = 8'd10; step();
        coin_value = 8'd5; cancel = 1'b1; step();
        n_checks++; if (coin_reject !== 1'b1 || change_valid !== 1'b1 || change_amount !== 8'd10 || busy !== 1'b1)
            $display("FAIL cancel_refund: got rej=%b cv=%b amt=%0d busy=%b want 1 1 10 1",
                     coin_reject, change_valid, change_amount, busy);
        else n_pass++;
        idle_inputs(); step();
        n_checks++; if (credit !== 8'd0 || change_valid !== 1'b0)
            $display("FAIL cancel_after: got credit=%0d cv=%b want 0 0", credit, change_valid);
        else n_pass++;
        settle();
        coin_valid = 1'b1; coin_value = 8'd10; step();
        coin_valid = 1'b0;
        waited = 0;
        while (change_valid !== 1'b1 && waited < 100) begin
            step();
            waited++;
        end
        n_checks++; if (waited != Tmo || change_amount !== 8'd10)
            $display("FAIL timeout_refund: got cycles=%0d amt=%0d want %0d 10", waited, change_amount, Tmo);
        else n_pass++;
        settle();
    endtask

    task automatic test_unaffordable_reset();
        idle_inputs(); coin_valid = 1'b1; coin_value = 8'd10; step();
        coin_valid = 1'b0; U1 = 1'b1; step();
        n_checks++; if (U1_out !== 1'b0 || coin !== 8'd0 || busy !== 1'b0 || credit !== 8'd10)
            $display("FAIL unaff_ignored: got u1=%b coin=%0d busy=%b credit=%0d want 0 0 0 10",
                     U1_out, coin, busy, credit);
        else n_pass++;
        U1 = 1'b0; reset = 1'b1; step();
        reset = 1'b0;
        n_checks++; if ({coin, T3_out, R2_out, U1_out, credit, coin_reject, change_valid, change_amount, busy} !== '0)
            $display("FAIL midreset_outputs: got %h want 0",
                     {coin, T3_out, R2_out, U1_out, credit, coin_reject, change_valid, change_amount, busy});
        else n_pass++;
        step();
        n_checks++; if (change_valid !== 1'b0 || credit !== 8'd0)
            $display("FAIL midreset_norefund: got cv=%b credit=%0d want 0 0", change_valid, credit);
        else n_pass++;
        settle();
    endtask

    task automatic test_random();
        exp_t got;
        int errs;
        bit quiet;
        errs = 0;
        for (int i = 0; i < 4000; i++) begin
            quiet = ((i % 300) > 250);
            reset = (i == 0) || ($urandom_range(0, 999) < 3);
            coin_valid = !quiet && ($urandom_range(0, 99) < 25);
            case ($urandom_range(0, 9))
                0, 1:    coin_value = 8'd5;
                2, 3:    coin_value = 8'd10;
                4, 5:    coin_value = 8'd20;
                6:       coin_value = 8'd7;
                7:       coin_value = 8'd0;
                8:       coin_value = 8'd15;
                default: coin_value = 8'd255;
            endcase
            T3     = !quiet && ($urandom_range(0, 99) < 4);
            R2     = !quiet && ($urandom_range(0, 99) < 4);
            U1     = !quiet && ($urandom_range(0, 99) < 4);
            cancel = !quiet && ($urandom_range(0, 999) < 15);
            @(posedge clk);
            model_step();
            #1;
            got = {coin, T3_out, R2_out, U1_out, credit, coin_reject, change_valid, change_amount, busy};
            n_checks++;
            if (got !== exp_cur) begin
                errs++;
                if (errs <= 10)
                    $display("FAIL random_cycle%0d: got %h want %h", i, got, exp_cur);
            end else n_pass++;
        end
        reset = 1'b0;
        settle();
    endtask

    initial begin
        exp_cur = '0;
        m_idle  = 0;
        test_reset();
        test_tea_exact();
        test_ceiling_coffee();
        test_illegal_coin();
        test_priority();
        test_cancel_timeout();
        test_unaffordable_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
